reg_ring_initiator: RTL and testbench
=====================================

# reg_ring_initiator

Ring master for the UDP register ring. Converts single local register commands into one-cycle request pulses launched at the head of the ring, then waits for the same request to come back from the tail. Returns read data and an error flag to the local requester. Sits upstream of all register responder blocks (rate limiter regs, etc.) and closes the ring; it is the only master on the ring.

## Interface
Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the source tag carried on the ring
- SRC_ID, 2'd1, source tag stamped on every request this block issues
- TIMEOUT, 127, cycles to wait in WAIT before aborting; legal range 1..255

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_req  in  1  local command strobe, sampled only when busy=0
- cmd_rd_wr_L  in  1  1=read, 0=write
- cmd_addr  in  `UDP_REG_ADDR_WIDTH  register address
- cmd_data  in  `CPCI_NF2_DATA_WIDTH  write data, don't-care for reads
- busy  out  1  command in flight; cmd_req ignored while high
- cmd_done  out  1  one-cycle completion pulse
- cmd_rd_data  out  `CPCI_NF2_DATA_WIDTH  result data, valid with cmd_done, held until next cmd_done
- cmd_err  out  1  no responder acked or timeout; valid with cmd_done, held until next cmd_done
- stray_count  out  8  saturating count of ring returns not matching an outstanding request
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring head
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring head
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring head
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring head
- reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in  in  widths as outputs  ring tail

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: busy=0. When cmd_req=1, latch rd_wr_L/addr/data and go to ISSUE.
- ISSUE: for exactly one cycle drive reg_req_out=1, reg_ack_out=0, reg_src_out=SRC_ID, plus the latched rd_wr_L/addr/data. Clear the timer and go to WAIT.
- WAIT: ring outputs are all zero. The timer increments each cycle.
  - A match is reg_req_in=1 and reg_src_in=SRC_ID. On a match, capture reg_ack_in and reg_data_in and go to DONE.
  - If the timer reaches TIMEOUT with no match, mark a timeout and go to DONE.
  - If a match and timer==TIMEOUT occur in the same cycle, the match wins.
- DONE: one cycle. cmd_done=1.
  - Match with ack=1: cmd_rd_data = captured data, cmd_err=0. For writes, the returned data is still reported.
  - Match with ack=0: cmd_rd_data=32'hdead_beef, cmd_err=1.
  - Timeout: cmd_rd_data=32'hdead_beef, cmd_err=1.
  - Then go to IDLE.
- Strays: any reg_req_in=1 outside WAIT, or in WAIT with src≠SRC_ID, increments stray_count (saturates at 255) and is otherwise dropped. A late return after a timeout is therefore counted as a stray.
- busy=1 in ISSUE, WAIT and DONE. cmd_req in those states is ignored, not queued.
- Mid-operation reset: abandon the in-flight request and go to IDLE. A subsequent return is counted as a stray.

## Timing
- All outputs are registered.
- Reset values: every ring output 0, busy=0, cmd_done=0, cmd_rd_data=0, cmd_err=0, stray_count=0, state IDLE, timer 0.
- cmd_req sampled at edge N (IDLE) gives busy=1 and reg_req_out=1 during cycle N+1.
- Ring latency L (return sampled L cycles after the reg_req_out cycle) gives cmd_done L+1 cycles after the reg_req_out cycle.
- Back-to-back: busy falls the cycle after cmd_done. The next cmd_req can be sampled at the edge ending that cycle, giving a minimum spacing of 4 cycles per command with L=1.
- Timeout: cmd_done occurs TIMEOUT+1 cycles after the reg_req_out cycle.

## Test plan
- Read hit: responder at ring latency 2 returns ack=1, data 32'h0000_0005 for addr A -> reg_req_out pulses once with src=1, rd_wr_L=1. cmd_done 3 cycles later, cmd_rd_data=5, cmd_err=0.
- Write then read: write 32'h0001_86A0, then read it back -> second cmd_done returns 32'h0001_86A0. cmd_req asserted during busy produces no extra reg_req_out.
- No responder: ring is a 1-cycle pass-through with ack_in=0 -> cmd_done with cmd_rd_data=32'hdead_beef, cmd_err=1.
- Timeout: TIMEOUT=10, no return -> cmd_done 11 cycles after the request pulse, err=1. Injecting the return 5 cycles later -> stray_count=1.
- Strays: 300 returns injected with src=2 while idle -> stray_count=255 (saturated), no cmd_done.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> all outputs 0, busy=0. The late return increments stray_count to 1, and a new command then completes normally.

Source files
------------

// File: rtl/reg_ring_initiator.sv
// Single master of the UDP register ring: launches one request at the ring head,
// waits for it to come back at the tail, and reports data/error to the local requester.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_initiator #(
    parameter int                           UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = 2'd1,
    parameter int                           TIMEOUT           = 127
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_req,
    input  logic                             cmd_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  cmd_data,
    output logic                             busy,
    output logic                             cmd_done,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]  cmd_rd_data,
    output logic                             cmd_err,
    output logic [7:0]                       stray_count,
    output logic                             reg_req_out,
    output logic                             reg_ack_out,
    output logic                             reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,
    input  logic                             reg_req_in,
    input  logic                             reg_ack_in,
    input  logic                             reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in
);
    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam logic [DW-1:0] ERR_DATA  = DW'(32'hdead_beef);
    localparam logic [7:0]    TIMEOUT_T = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      timer_reg, timer_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic [DW-1:0]   rd_data_reg, rd_data_next;
    logic            err_reg, err_next;
    logic [7:0]      stray_reg, stray_next;
    logic            ring_req_reg, ring_req_next;
    logic            ring_rw_reg, ring_rw_next;
    logic [AW-1:0]   ring_addr_reg, ring_addr_next;
    logic [DW-1:0]   ring_data_reg, ring_data_next;
    logic [UDP_REG_SRC_WIDTH-1:0] ring_src_reg, ring_src_next;
    logic            match;

    // Returned rd_wr_L/addr are not needed to identify our request; only src is.
    logic unused_ring_fields;
    assign unused_ring_fields = ^{reg_rd_wr_L_in, reg_addr_in};

    assign match = reg_req_in && (reg_src_in == SRC_ID);

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        rd_data_next   = rd_data_reg;
        err_next       = err_reg;
        stray_next     = stray_reg;
        ring_req_next  = 1'b0;
        ring_rw_next   = 1'b0;
        ring_addr_next = '0;
        ring_data_next = '0;
        ring_src_next  = '0;
        case (state_reg)
            IDLE: begin
                if (cmd_req) begin
                    // The command is latched straight into the ring head registers.
                    state_next     = ISSUE;
                    busy_next      = 1'b1;
                    ring_req_next  = 1'b1;
                    ring_rw_next   = cmd_rd_wr_L;
                    ring_addr_next = cmd_addr;
                    ring_data_next = cmd_data;
                    ring_src_next  = SRC_ID;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                timer_next = '0;
            end
            WAIT: begin
                timer_next = timer_reg + 8'd1;
                if (match) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    rd_data_next = reg_ack_in ? reg_data_in : ERR_DATA;
                    err_next     = !reg_ack_in;
                end else if (timer_next == TIMEOUT_T) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    rd_data_next = ERR_DATA;
                    err_next     = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
        // Anything on the tail that is not our outstanding request is dropped and counted.
        if (reg_req_in && !(state_reg == WAIT && reg_src_in == SRC_ID) && stray_reg != 8'hff)
            stray_next = stray_reg + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_data_reg   <= '0;
            err_reg       <= 1'b0;
            stray_reg     <= '0;
            ring_req_reg  <= 1'b0;
            ring_rw_reg   <= 1'b0;
            ring_addr_reg <= '0;
            ring_data_reg <= '0;
            ring_src_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            rd_data_reg   <= rd_data_next;
            err_reg       <= err_next;
            stray_reg     <= stray_next;
            ring_req_reg  <= ring_req_next;
            ring_rw_reg   <= ring_rw_next;
            ring_addr_reg <= ring_addr_next;
            ring_data_reg <= ring_data_next;
            ring_src_reg  <= ring_src_next;
        end
    end

    assign busy            = busy_reg;
    assign cmd_done        = done_reg;
    assign cmd_rd_data     = rd_data_reg;
    assign cmd_err         = err_reg;
    assign stray_count     = stray_reg;
    assign reg_req_out     = ring_req_reg;
    assign reg_ack_out     = 1'b0;
    assign reg_rd_wr_L_out = ring_rw_reg;
    assign reg_addr_out    = ring_addr_reg;
    assign reg_data_out    = ring_data_reg;
    assign reg_src_out     = ring_src_reg;

endmodule

// File: tb/tb_reg_ring_initiator.sv
// Directed bench for reg_ring_initiator: a delay-line ring with one responder register,
// or a manually driven tail for timeout/stray/reset scenarios.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_reg_ring_initiator;
    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_A = 23'h000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cmd_req, cmd_rd_wr_L;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          busy, cmd_done, cmd_err;
    logic [DW-1:0] cmd_rd_data;
    logic [7:0]    stray_count;
    logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [1:0]    reg_src_out;
    logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [AW-1:0] reg_addr_in;
    logic [DW-1:0] reg_data_in;
    logic [1:0]    reg_src_in;

    reg_ring_initiator #(.UDP_REG_SRC_WIDTH(2), .SRC_ID(2'd1), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .cmd_req(cmd_req), .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .cmd_done(cmd_done), .cmd_rd_data(cmd_rd_data), .cmd_err(cmd_err),
        .stray_count(stray_count),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
        .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
    );

    // Ring model: stage 0 holds the responder, later stages add latency.
    logic          ring_on, resp_en;
    int            lat;
    logic [DW-1:0] resp_mem;
    logic          inj_req, inj_ack;
    logic [1:0]    inj_src;
    logic          p_req [4] = '{4{1'b0}};
    logic          p_ack [4] = '{4{1'b0}};
    logic          p_rw  [4] = '{4{1'b0}};
    logic [AW-1:0] p_addr[4] = '{4{'0}};
    logic [DW-1:0] p_data[4] = '{4{'0}};
    logic [1:0]    p_src [4] = '{4{2'b0}};
    logic          hit;

    assign hit = resp_en && reg_req_out && (reg_addr_out == ADDR_A);

    always @(posedge clk) begin
        p_req[0]  <= reg_req_out;
        p_ack[0]  <= reg_ack_out | hit;
        p_rw[0]   <= reg_rd_wr_L_out;
        p_addr[0] <= reg_addr_out;
        p_data[0] <= (hit && reg_rd_wr_L_out) ? resp_mem : reg_data_out;
        p_src[0]  <= reg_src_out;
        if (hit && !reg_rd_wr_L_out) resp_mem <= reg_data_out;
        for (int i = 3; i > 0; i--) begin
            p_req[i]  <= p_req[i-1];
            p_ack[i]  <= p_ack[i-1];
            p_rw[i]   <= p_rw[i-1];
            p_addr[i] <= p_addr[i-1];
            p_data[i] <= p_data[i-1];
            p_src[i]  <= p_src[i-1];
        end
    end

    always_comb begin
        reg_req_in     = inj_req;
        reg_ack_in     = inj_ack;
        reg_rd_wr_L_in = 1'b1;
        reg_addr_in    = ADDR_A;
        reg_data_in    = 32'h1234_5678;
        reg_src_in     = inj_src;
        if (ring_on) begin
            reg_req_in     = p_req[lat-1];
            reg_ack_in     = p_ack[lat-1];
            reg_rd_wr_L_in = p_rw[lat-1];
            reg_addr_in    = p_addr[lat-1];
            reg_data_in    = p_data[lat-1];
            reg_src_in     = p_src[lat-1];
        end
    end

    // Event monitor: counts request pulses and completions, records their cycles.
    int            cyc = 0, req_cnt = 0, req_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [DW-1:0] done_data = '0;
    logic          done_err = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_req_out) begin
            req_cnt <= req_cnt + 1;
            req_cyc <= cyc;
        end
        if (cmd_done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_data <= cmd_rd_data;
            done_err  <= cmd_err;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int hold, output int rq_before);
        rq_before   = req_cnt;
        cmd_rd_wr_L = rw;
        cmd_addr    = a;
        cmd_data    = d;
        cmd_req     = 1'b1;
        @(negedge clk);
        check("issue_req",  64'(reg_req_out), 64'(1));
        check("issue_busy", 64'(busy), 64'(1));
        check("issue_src",  64'(reg_src_out), 64'(1));
        check("issue_rw",   64'(reg_rd_wr_L_out), 64'(rw));
        check("issue_addr", 64'(reg_addr_out), 64'(a));
        repeat (hold) @(negedge clk);
        cmd_req = 1'b0;
        $display("cmd issued rw=%0d addr=%0h data=%0h", rw, a, d);
    endtask

    task automatic wait_done(input string tag);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt - start), 64'(1));
        $display("%s done data=%0h err=%0d latency=%0d", tag, done_data, done_err, done_cyc - req_cyc);
    endtask

    int rq, dc;

    initial begin
        reset = 1'b1; cmd_req = 1'b0; cmd_rd_wr_L = 1'b0; cmd_addr = '0; cmd_data = '0;
        ring_on = 1'b0; resp_en = 1'b1; lat = 2; resp_mem = 32'h0000_0005;
        inj_req = 1'b0; inj_ack = 1'b0; inj_src = 2'd0;
        repeat (4) @(negedge clk);
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_done",  64'(cmd_done), 64'(0));
        check("rst_data",  64'(cmd_rd_data), 64'(0));
        check("rst_err",   64'(cmd_err), 64'(0));
        check("rst_stray", 64'(stray_count), 64'(0));
        check("rst_ring",  64'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_src_out}), 64'(0));
        check("rst_rdata", 64'(reg_data_out), 64'(0));
        reset = 1'b0;
        ring_on = 1'b1;
        repeat (2) @(negedge clk);

        // Read hit, latency 2
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        wait_done("read_hit");
        check("rh_data",    64'(done_data), 64'(32'h5));
        check("rh_err",     64'(done_err), 64'(0));
        check("rh_latency", 64'(done_cyc - req_cyc), 64'(3));
        check("rh_pulses",  64'(req_cnt - rq), 64'(1));
        check("rh_busy_fall", 64'(busy), 64'(0));
        check("rh_done_low",  64'(cmd_done), 64'(0));
        check("rh_held",      64'(cmd_rd_data), 64'(32'h5));

        // Write with cmd_req held during busy, then read back
        start_cmd(1'b0, ADDR_A, 32'h0001_86A0, 2, rq);
        wait_done("write");
        check("wr_pulses", 64'(req_cnt - rq), 64'(1));
        check("wr_err",    64'(done_err), 64'(0));
        check("wr_data",   64'(done_data), 64'(32'h0001_86A0));
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        wait_done("readback");
        check("rb_data", 64'(done_data), 64'(32'h0001_86A0));
        check("rb_err",  64'(done_err), 64'(0));

        // No responder, 1-cycle pass-through
        resp_en = 1'b0; lat = 1;
        repeat (2) @(negedge clk);
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        wait_done("no_resp");
        check("nr_data",    64'(done_data), 64'(32'hdead_beef));
        check("nr_err",     64'(done_err), 64'(1));
        check("nr_latency", 64'(done_cyc - req_cyc), 64'(2));

        // Timeout with no return, then a late return
        ring_on = 1'b0;
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        wait_done("timeout");
        check("to_latency", 64'(done_cyc - req_cyc), 64'(11));
        check("to_err",     64'(done_err), 64'(1));
        check("to_data",    64'(done_data), 64'(32'hdead_beef));
        dc = done_cnt;
        repeat (4) @(negedge clk);
        inj_req = 1'b1; inj_src = 2'd1; inj_ack = 1'b1;
        @(negedge clk);
        inj_req = 1'b0; inj_ack = 1'b0;
        @(negedge clk);
        check("late_stray", 64'(stray_count), 64'(1));
        check("late_nodone", 64'(done_cnt - dc), 64'(0));
        $display("late return stray_count=%0d", stray_count);

        // 300 strays from another source while idle
        inj_req = 1'b1; inj_src = 2'd2;
        repeat (300) @(negedge clk);
        inj_req = 1'b0; inj_src = 2'd0;
        @(negedge clk);
        check("stray_sat",    64'(stray_count), 64'(255));
        check("stray_nodone", 64'(done_cnt - dc), 64'(0));
        check("stray_idle",   64'(busy), 64'(0));
        $display("stray burst stray_count=%0d", stray_count);

        // Reset during WAIT, late return becomes a stray
        ring_on = 1'b1; resp_en = 1'b1; lat = 3;
        repeat (4) @(negedge clk);
        dc = done_cnt;
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_busy",  64'(busy), 64'(0));
        check("mr_done",  64'(cmd_done), 64'(0));
        check("mr_data",  64'(cmd_rd_data), 64'(0));
        check("mr_err",   64'(cmd_err), 64'(0));
        check("mr_stray", 64'(stray_count), 64'(0));
        check("mr_ring",  64'(reg_req_out), 64'(0));
        repeat (3) @(negedge clk);
        check("mr_late_stray", 64'(stray_count), 64'(1));
        check("mr_nodone",     64'(done_cnt - dc), 64'(0));
        $display("reset mid-wait stray_count=%0d", stray_count);
        start_cmd(1'b1, ADDR_A, '0, 0, rq);
        wait_done("post_reset");
        check("pr_data",    64'(done_data), 64'(32'h0001_86A0));
        check("pr_err",     64'(done_err), 64'(0));
        check("pr_latency", 64'(done_cyc - req_cyc), 64'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
